fu_stage_fifo: RTL and testbench
================================

FU_STAGE_FIFO -- requirements
Module: fu_stage_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-002 SHALL have parameter XLEN, default 64, register-data and store-data width.
REQ-003 SHALL have parameter ADDR_W, default 32, memory-address width.
REQ-004 SHALL have parameter PID_W, default 2, physical-ID width.
REQ-005 SHALL have parameter AFULL_LVL, default DEPTH-1, count at which almost_full_o asserts; range 1..DEPTH.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush (jump/redirect).
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  space available to upstream.
- in_i  in  fu_entry_t  packed payload: rdWriteEnable, rdAddr[4:0], rdData[XLEN], pID[PID_W], opCode[6:0], funct3[2:0], readAddr[ADDR_W], writeAddr[ADDR_W], writeData[XLEN], writeMask[XLEN/8].
- valid_o  out  1  head entry valid to FU/RAM.
- ready_i  in  1  FU/RAM consumes head.
- out_o  out  fu_entry_t  head-entry payload.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- almost_full_o  out  1  count_o >= AFULL_LVL.

Function
REQ-007 Push SHALL occur when valid_i && ready_o && !flush_i; pop when valid_o && ready_i && !flush_i.
REQ-008 ready_o SHALL equal (count_o != DEPTH), from registered state only, with no combinational path from ready_i.
REQ-009 valid_o SHALL equal (count_o != 0), from registered state only.
REQ-010 out_o SHALL present the entry at the read pointer (show-ahead) when valid_o=1, and all-zero when valid_o=0.
REQ-011 Latency SHALL be 1 cycle: an entry pushed at edge N appears on out_o with valid_o=1 after edge N; no same-cycle bypass.
REQ-012 Pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
REQ-013 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-014 When full, a pop SHALL not allow a same-cycle push (ready_o=0); count_o falls to DEPTH-1.
REQ-015 When empty, an asserted ready_i SHALL have no effect.
REQ-016 flush_i SHALL zero both pointers and count_o at the next edge, discarding the same-cycle push and pop; it has priority over push/pop and below reset.
REQ-017 Payload fields SHALL be stored and returned bit-exact, in FIFO order.
REQ-018 An upstream entry held with valid_i=1 and ready_o=0 SHALL not be lost; it is accepted on the first cycle ready_o=1.

Reset
REQ-019 While reset=1 at an edge, pointers and count_o SHALL clear, so valid_o=0, ready_o=1, almost_full_o=0 (AFULL_LVL>=1) and out_o=0 after that edge.
REQ-020 Storage array SHALL not be reset; reset mid-operation discards all entries.

Structure
REQ-021 fu_entry_t packed struct, parameterised widths and default constants SHALL live in shared package fu_pkg.
REQ-022 Storage SHALL be sub-module fu_fifo_mem (DEPTH x $bits(fu_entry_t), 1 write port, 1 async read port); pointer/count control stays in fu_stage_fifo.

Verification (DEPTH=4, XLEN=64)
REQ-023 After reset, push rdAddr=5, rdData=0xDEAD_BEEF -> valid_o=1 next cycle, out_o.rdAddr=5, rdData=0xDEAD_BEEF, count_o=1.
REQ-024 Push 4 entries with ready_i=0 -> count_o=4, ready_o=0, almost_full_o=1 from count 3; 5th valid_i held until one pop, then accepted.
REQ-025 Push and pop every cycle for 10 cycles from count 2 -> count_o stays 2; outputs in order; pointers wrap twice.
REQ-026 flush_i with count 3 and valid_i=1 -> next cycle count_o=0, valid_o=0, out_o=0; pushed entry discarded.
REQ-027 reset asserted with count 2 mid-stream -> next cycle count_o=0, ready_o=1; first post-reset push returns its own data, not stale data.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared types and default widths for the functional-unit stage FIFO.
// The packed payload is laid out MSB-first in field order.
package fu_pkg;

  localparam int FU_DEPTH  = 4;
  localparam int FU_XLEN   = 64;
  localparam int FU_ADDR_W = 32;
  localparam int FU_PID_W  = 2;

  typedef struct packed {
    logic                   rdWriteEnable;
    logic [4:0]             rdAddr;
    logic [FU_XLEN-1:0]     rdData;
    logic [FU_PID_W-1:0]    pID;
    logic [6:0]             opCode;
    logic [2:0]             funct3;
    logic [FU_ADDR_W-1:0]   readAddr;
    logic [FU_ADDR_W-1:0]   writeAddr;
    logic [FU_XLEN-1:0]     writeData;
    logic [FU_XLEN/8-1:0]   writeMask;
  } fu_entry_t;

  // Entry width implied by a set of widths; it must equal $bits(fu_entry_t)
  // for the module parameters to be consistent with the package struct.
  function automatic int fu_entry_width(input int xlen, input int addr_w, input int pid_w);
    return 1 + 5 + xlen + pid_w + 7 + 3 + 2 * addr_w + xlen + xlen / 8;
  endfunction

endpackage

// File: rtl/fu_fifo_mem.sv
// Entry storage for the stage FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fu_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fu_stage_fifo.sv
// Show-ahead FIFO between issue and a functional unit / RAM port.
// Handshake outputs depend only on registered occupancy; flush empties it.
module fu_stage_fifo
  import fu_pkg::*;
#(
  parameter int DEPTH     = FU_DEPTH,
  parameter int XLEN      = FU_XLEN,
  parameter int ADDR_W    = FU_ADDR_W,
  parameter int PID_W     = FU_PID_W,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  fu_entry_t                  in_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output fu_entry_t                  out_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = fu_entry_width(XLEN, ADDR_W, PID_W);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;

  assign ready_o       = (count_q != CNT_W'(DEPTH));
  assign valid_o       = (count_q != '0);
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CNT_W'(AFULL_LVL));

  assign push = valid_i && ready_o && !flush_i;
  assign pop  = valid_o && ready_i && !flush_i;

  // Pointers are exactly PTR_W bits, so DEPTH-1 -> 0 wrap needs no compare.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign wr_data = in_i;

  fu_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Stale storage is never visible: the payload is masked while empty.
  assign out_o = valid_o ? fu_entry_t'(rd_data) : '0;

endmodule

// File: tb/tb_fu_stage_fifo.sv
// Self-checking bench for fu_stage_fifo against a queue-based reference model.
module tb_fu_stage_fifo;
  import fu_pkg::*;

  localparam int DEPTH = 4;

  logic      clk = 1'b0;
  logic      reset;
  logic      flush_i;
  logic      valid_i;
  logic      ready_o;
  fu_entry_t in_i;
  logic      valid_o;
  logic      ready_i;
  fu_entry_t out_o;
  logic [2:0] count_o;
  logic      almost_full_o;

  fu_entry_t model_q[$];
  int checks = 0;
  int fails  = 0;

  fu_stage_fifo dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .in_i          (in_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .out_o         (out_o),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fu_entry_t randEntry();
    fu_entry_t e;
    e.rdWriteEnable = 1'($urandom);
    e.rdAddr        = 5'($urandom);
    e.rdData        = {$urandom, $urandom};
    e.pID           = 2'($urandom);
    e.opCode        = 7'($urandom);
    e.funct3        = 3'($urandom);
    e.readAddr      = $urandom;
    e.writeAddr     = $urandom;
    e.writeData     = {$urandom, $urandom};
    e.writeMask     = 8'($urandom);
    return e;
  endfunction

  task automatic checkAll(input string tag);
    fu_entry_t exp_out;
    exp_out = (model_q.size() != 0) ? model_q[0] : '0;
    checkOutput({tag, ".count"}, 256'(count_o), 256'(model_q.size()));
    checkOutput({tag, ".valid"}, 256'(valid_o), 256'(model_q.size() != 0));
    checkOutput({tag, ".ready"}, 256'(ready_o), 256'(model_q.size() != DEPTH));
    checkOutput({tag, ".afull"}, 256'(almost_full_o), 256'(model_q.size() >= DEPTH - 1));
    checkOutput({tag, ".out"}, 256'(out_o), 256'(exp_out));
  endtask

  // One clock cycle: drive inputs, advance the model by the handshake rules, check after the edge.
  task automatic applyStimulus(input logic v, input logic f, input logic r, input fu_entry_t e,
                               input string tag);
    bit do_push, do_pop;
    valid_i = v;
    flush_i = f;
    ready_i = r;
    in_i    = e;
    do_push = v && (model_q.size() < DEPTH) && !f;
    do_pop  = r && (model_q.size() > 0) && !f;
    @(posedge clk);
    #1;
    if (f) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    reset   = 1'b1;
    valid_i = 1'b1;
    in_i    = randEntry();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    valid_i = 1'b0;
    model_q.delete();
    checkAll(tag);
  endtask

  initial begin
    fu_entry_t e;
    fu_entry_t held;
    reset   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    in_i    = '0;

    doReset("reset");

    // Empty FIFO ignores ready_i.
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "empty_pop");

    e = randEntry();
    e.rdAddr = 5'd5;
    e.rdData = 64'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 1'b0, e, "first_push");
    checkOutput("first_push.rdAddr", 256'(out_o.rdAddr), 256'(5));
    checkOutput("first_push.rdData", 256'(out_o.rdData), 256'(64'hDEAD_BEEF));

    // Fill to DEPTH, then hold a fifth entry until one pop frees space.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "fill");
    ready_i = 1'b1;
    #1;
    checkOutput("full_ready_comb", 256'(ready_o), 256'(0));
    held = randEntry();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, held, "hold_full");
    applyStimulus(1'b1, 1'b0, 1'b1, held, "full_pop");
    applyStimulus(1'b1, 1'b0, 1'b0, held, "held_accept");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0, "drain");

    // Streaming at count 2: occupancy constant, pointers wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "pre_stream");
    applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "pre_stream");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, randEntry(), "stream");
    checkOutput("stream.count2", 256'(count_o), 256'(2));

    // Flush at count 3 with a concurrent push.
    applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "pre_flush");
    applyStimulus(1'b1, 1'b1, 1'b1, randEntry(), "flush");
    checkOutput("flush.count0", 256'(count_o), 256'(0));

    // Reset mid-stream, then confirm fresh data rather than stale storage.
    applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "pre_reset");
    applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "pre_reset");
    doReset("mid_reset");
    e = randEntry();
    applyStimulus(1'b1, 1'b0, 1'b0, e, "post_reset_push");
    checkOutput("post_reset_data", 256'(out_o), 256'(e));

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 1)), randEntry(), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
